// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch stage between the PC register and decode.
// Optional IF_MISALIGN_CHK_EN flags misaligned PCs instead of fetching them.
module if_fetch_unit #(
  parameter int FIFO_DEPTH  = 2,
  parameter int MAX_OUTST   = 2,
  parameter int BOOT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  output logic        pc_wr_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic        id_misalign_o
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int QW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW  = $clog2(MAX_OUTST + 1);
  localparam int BW  = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int BL  = (BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0;
  localparam logic [QW-1:0] QLAST = QW'(MAX_OUTST - 1);
  localparam logic [CW-1:0] OMAX  = CW'(MAX_OUTST);
  localparam logic [BW-1:0] BLAST = BW'(BL);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
`ifdef IF_MISALIGN_CHK_EN
    logic        mis;
`endif
    logic [31:0] pc;
    logic [31:0] instr;
  } fe_entry_t;

  state_t         state, state_nxt;
  logic [BW-1:0]  boot_cnt;
  logic [CW-1:0]  outst, outst_nxt;
  logic [CW-1:0]  discard, discard_nxt;
  logic [FCW-1:0] fcnt;
  logic [AW-1:0]  rptr, wptr;
  logic [QW-1:0]  qrptr, qwptr;
  logic [31:0]    qpc [MAX_OUTST];
  fe_entry_t      fifo_q [FIFO_DEPTH];
  fe_entry_t      head, ent;

  logic mis, credit, req_acc, mis_push;
  logic rv, drop, rsp_push, push, pop;
  int   free_slots;

`ifdef IF_MISALIGN_CHK_EN
  assign mis = pc_i[1:0] != 2'b00;
`else
  assign mis = 1'b0;
`endif

  assign pop = id_valid_o && id_ready_i;

  // slots not yet claimed by the FIFO or by live in-flight fetches
  assign free_slots = FIFO_DEPTH - int'(fcnt) - int'(outst)
                    + int'(discard) + int'(pop);

  assign credit = (state != BOOT) && !flush_i
               && (outst < OMAX) && (free_slots > 0);

  assign imem_req_o  = credit && !mis;
  assign imem_addr_o = pc_i;
  assign req_acc     = imem_req_o && imem_gnt_i;
  assign mis_push    = credit && mis && (outst == '0);
  assign pc_wr_o     = req_acc || flush_i || mis_push;

  // a response with nothing outstanding is a leftover from before reset
  assign rv       = imem_rvalid_i && (outst != '0);
  assign drop     = rv && (discard != '0);
  assign rsp_push = rv && !drop && !flush_i;
  assign push     = rsp_push || mis_push;

  always_comb begin
    outst_nxt = outst;
    unique case (1'b1)
      req_acc && !rv: outst_nxt = outst + 1'b1;
      rv && !req_acc: outst_nxt = outst - 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    discard_nxt = discard;
    unique case (1'b1)
      flush_i: discard_nxt = outst_nxt;
      drop:    discard_nxt = discard - 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    if (boot_cnt == BLAST) state_nxt = RUN;
      RUN:     if (discard_nxt != '0) state_nxt = DRAIN;
      DRAIN:   if (discard_nxt == '0) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      boot_cnt <= '0;
      outst    <= '0;
      discard  <= '0;
    end else begin
      state   <= state_nxt;
      outst   <= outst_nxt;
      discard <= discard_nxt;
      if (state == BOOT) boot_cnt <= boot_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qrptr <= '0;
      qwptr <= '0;
    end else begin
      if (req_acc) qwptr <= (qwptr == QLAST) ? '0 : qwptr + 1'b1;
      if (rv)      qrptr <= (qrptr == QLAST) ? '0 : qrptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (req_acc) qpc[qwptr] <= pc_i;
  end

  always_comb begin
    ent = '0;
    if (mis_push) begin
      ent.pc    = pc_i;
      ent.instr = NOP;
`ifdef IF_MISALIGN_CHK_EN
      ent.mis   = 1'b1;
`endif
    end else begin
      ent.pc    = qpc[qrptr];
      ent.instr = imem_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr <= '0;
      wptr <= '0;
      fcnt <= '0;
    end else if (flush_i) begin
      rptr <= '0;
      wptr <= '0;
      fcnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case (1'b1)
        push && !pop: fcnt <= fcnt + 1'b1;
        pop && !push: fcnt <= fcnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr] <= ent;
  end

  assign head       = fifo_q[rptr];
  assign id_valid_o = fcnt != '0;
  assign id_instr_o = id_valid_o ? head.instr : NOP;
  assign id_pc_o    = id_valid_o ? head.pc : 32'h0;
`ifdef IF_MISALIGN_CHK_EN
  assign id_misalign_o = id_valid_o && head.mis;
`endif

  a_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    push && !pop |-> fcnt != FCW'(FIFO_DEPTH));

  a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
    imem_req_o && !imem_gnt_i |=>
      flush_i || (imem_req_o && $stable(imem_addr_o)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed cycle vectors for if_fetch_unit.
// Models the PC register and an in-order imem around the DUT.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst_n;
  logic [31:0] pc, tgt;
  logic        pc_wr, flush, req, gnt, rvalid, ready, valid;
  logic [31:0] addr, rdata, instr, idpc;
`ifdef IF_MISALIGN_CHK_EN
  logic        mis;
`endif

  int n_vec, n_bad, cyc;
  logic [31:0] mq [$];

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        ready;
    logic        flush;
    logic        hold;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        pcwr;
    logic        valid;
    logic [31:0] idpc;
    logic        mis;
  } vec_t;

  vec_t tbl [$];

  if_fetch_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .pc_i(pc),
    .pc_wr_o(pc_wr),
    .flush_i(flush),
    .imem_req_o(req),
    .imem_addr_o(addr),
    .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid),
    .imem_rdata_i(rdata),
    .id_valid_o(valid),
    .id_ready_i(ready),
    .id_instr_o(instr),
    .id_pc_o(idpc)
`ifdef IF_MISALIGN_CHK_EN
    ,
    .id_misalign_o(mis)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register: +4 on accepted fetch, target on redirect
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 32'h0;
    else if (pc_wr) pc <= flush ? tgt : pc + 32'd4;
  end

  // imem: one-cycle minimum latency, in order
  always @(posedge clk) begin
    if (rvalid) void'(mq.pop_front());
    if (rst_n && req && gnt) mq.push_back(addr);
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic vec_t mk(
    input logic r, input logic g, input logic y,
    input logic f, input logic h, input logic [31:0] t,
    input logic eq, input logic [31:0] ea, input logic ew,
    input logic ev, input logic [31:0] ep);
    vec_t v;
    v.rst = r;   v.gnt = g;   v.ready = y;
    v.flush = f; v.hold = h;  v.tgt = t;
    v.req = eq;  v.addr = ea; v.pcwr = ew;
    v.valid = ev; v.idpc = ep; v.mis = 1'b0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    logic [31:0] ei;
    @(negedge clk);
    cyc++;
    rst_n  = v.rst;
    gnt    = v.gnt;
    ready  = v.ready;
    flush  = v.flush;
    tgt    = v.tgt;
    rvalid = (mq.size() != 0) && !v.hold;
    rdata  = rvalid ? word(mq[0]) : 32'h0;
    #1;
    chk("req", 32'(req), 32'(v.req));
    chk("addr", addr, v.addr);
    chk("pc_wr", 32'(pc_wr), 32'(v.pcwr));
    chk("id_valid", 32'(valid), 32'(v.valid));
    if (!v.rst || v.valid) begin
      ei = (v.valid && !v.mis) ? word(v.idpc) : NOP;
      chk("id_pc", idpc, v.idpc);
      chk("id_instr", instr, ei);
`ifdef IF_MISALIGN_CHK_EN
      chk("id_misalign", 32'(mis), 32'(v.mis));
`endif
    end
  endtask

  initial begin
    vec_t m;
    n_vec = 0; n_bad = 0; cyc = 0;
    rst_n = 1'b0; gnt = 1'b0; ready = 1'b0; flush = 1'b0;
    tgt = 32'h0; rvalid = 1'b0; rdata = 32'h0;

    // reset, boot, streaming 0,4,8
    tbl.push_back(mk(0,1,1,0,1,0, 0,32'h0,0,0,32'h0));
    tbl.push_back(mk(0,1,1,0,1,0, 0,32'h0,0,0,32'h0));
    tbl.push_back(mk(1,1,1,0,0,0, 0,32'h0,0,0,32'h0));
    tbl.push_back(mk(1,1,1,0,0,0, 1,32'h0,1,0,32'h0));
    tbl.push_back(mk(1,1,1,0,0,0, 1,32'h4,1,0,32'h0));
    tbl.push_back(mk(1,1,1,0,0,0, 1,32'h8,1,1,32'h0));
    tbl.push_back(mk(1,1,1,0,0,0, 1,32'hc,1,1,32'h4));
    // gnt low three cycles at 0x10
    tbl.push_back(mk(1,0,1,0,0,0, 1,32'h10,0,1,32'h8));
    tbl.push_back(mk(1,0,1,0,0,0, 1,32'h10,0,1,32'hc));
    tbl.push_back(mk(1,0,1,0,0,0, 1,32'h10,0,0,32'h0));
    tbl.push_back(mk(1,1,1,0,0,0, 1,32'h10,1,0,32'h0));
    tbl.push_back(mk(1,1,1,0,0,0, 1,32'h14,1,0,32'h0));
    tbl.push_back(mk(1,1,1,0,0,0, 1,32'h18,1,1,32'h10));
    // decode backpressure for five cycles
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1,1,0,0,0,0, 0,32'h1c,0,1,32'h14));
    tbl.push_back(mk(1,1,1,0,0,0, 1,32'h1c,1,1,32'h14));
    tbl.push_back(mk(1,1,1,0,0,0, 1,32'h20,1,1,32'h18));
    // two outstanding (0x20, 0x24), flush to 0x100
    tbl.push_back(mk(1,1,1,0,1,0, 1,32'h24,1,1,32'h1c));
    tbl.push_back(mk(1,1,1,1,1,32'h100, 0,32'h28,1,0,32'h0));
    tbl.push_back(mk(1,1,1,0,0,0, 0,32'h100,0,0,32'h0));
    tbl.push_back(mk(1,1,1,0,0,0, 1,32'h100,1,0,32'h0));
    tbl.push_back(mk(1,1,1,0,0,0, 1,32'h104,1,0,32'h0));
    tbl.push_back(mk(1,1,1,0,0,0, 1,32'h108,1,1,32'h100));
    tbl.push_back(mk(1,1,1,0,0,0, 1,32'h10c,1,1,32'h104));

    foreach (tbl[i]) step(tbl[i]);

    // flush together with rvalid and an id handshake
    step(mk(1,1,1,1,0,32'h200, 0,32'h110,1,1,32'h108));
    step(mk(1,1,1,0,0,0, 1,32'h200,1,0,32'h0));
    step(mk(1,1,1,0,0,0, 1,32'h204,1,0,32'h0));
    step(mk(1,1,1,0,0,0, 1,32'h208,1,1,32'h200));

    // top-of-memory fetch
    step(mk(1,1,1,1,0,32'hFFFF_FFFC, 0,32'h20c,1,1,32'h204));
    step(mk(1,1,1,0,0,0, 1,32'hFFFF_FFFC,1,0,32'h0));
    step(mk(1,1,1,0,0,0, 1,32'h0,1,0,32'h0));
    step(mk(1,1,1,0,0,0, 1,32'h4,1,1,32'hFFFF_FFFC));

    // reset with 0x4 outstanding; its late rvalid must be ignored
    step(mk(0,1,1,0,1,0, 0,32'h0,0,0,32'h0));
    step(mk(0,1,1,0,1,0, 0,32'h0,0,0,32'h0));
    step(mk(1,1,1,0,0,0, 0,32'h0,0,0,32'h0));
    step(mk(1,1,1,0,0,0, 1,32'h0,1,0,32'h0));
    step(mk(1,1,1,0,0,0, 1,32'h4,1,0,32'h0));
    step(mk(1,1,1,0,0,0, 1,32'h8,1,1,32'h0));

`ifdef IF_MISALIGN_CHK_EN
    step(mk(0,1,1,0,1,0, 0,32'h0,0,0,32'h0));
    step(mk(1,1,1,1,0,32'h102, 0,32'h0,1,0,32'h0));
    step(mk(1,1,0,0,0,0, 0,32'h102,1,0,32'h0));
    m = mk(1,1,0,0,0,0, 0,32'h106,1,1,32'h102);
    m.mis = 1'b1;
    step(m);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
